// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Even parity is the plain XOR reduction; odd parity flips it.
   function automatic logic frame_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push handshake between the register file (master) and the transmitter (slave).
interface uart_tx_buffered_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data_i;
   logic                      tx_valid_i;
   logic                      tx_ready_o;

   modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
   modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with show-ahead read data and a level counter one bit wider than the pointers.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [UART_DATA_BITS-1:0] wdata,
   output logic [UART_DATA_BITS-1:0] rdata,
   output logic [AW:0]               level,
   output logic                      full,
   output logic                      empty
);

   logic [UART_DATA_BITS-1:0] mem_r [DEPTH];
   logic [AW-1:0]             wr_ptr_r;
   logic [AW-1:0]             rd_ptr_r;
   logic [AW:0]               level_r;
   logic                      full_s;
   logic                      empty_s;
   logic                      push_ok_s;
   logic                      pop_ok_s;

   assign full_s    = (level_r == (AW+1)'(DEPTH));
   assign empty_s   = (level_r == {(AW+1){1'b0}});
   assign push_ok_s = push & ~full_s;
   assign pop_ok_s  = pop & ~empty_s;

   // Storage array; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and level bookkeeping; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign level = level_r;
   assign full  = full_s;
   assign empty = empty_s;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO feeding an 8N1/8N2 serialiser with a programmable baud divisor.
// Optional parity bit (8E1/8O1) is enabled with `define UART_TX_PARITY_EN.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_en_i,
   input  logic [DIV_WIDTH-1:0]          cfg_div_i,
   input  logic                          cfg_stop2_i,
   input  logic                          cfg_parity_odd_i,
   uart_tx_buffered_if.slave             tx_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          busy_o,
   output logic                          tx_o
);

   tx_state_t                 state_r;
   logic [DIV_WIDTH-1:0]      div_r;
   logic [DIV_WIDTH-1:0]      baud_r;
   logic [UART_DATA_BITS-1:0] shift_r;
   logic [2:0]                bit_r;
   logic                      stop2_r;
   logic                      stop_cnt_r;
   logic                      tx_r;
   logic                      busy_r;
`ifdef UART_TX_PARITY_EN
   logic                      parity_r;
`else
   logic                      unused_parity_s;
   assign unused_parity_s = cfg_parity_odd_i;
`endif

   logic [UART_DATA_BITS-1:0] fifo_rdata_s;
   logic                      fifo_full_s;
   logic                      fifo_empty_s;
   logic                      pop_s;
   logic                      bit_end_s;
   logic                      last_stop_s;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_if.tx_valid_i),
      .pop   (pop_s),
      .wdata (tx_if.tx_data_i),
      .rdata (fifo_rdata_s),
      .level (fifo_level_o),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign bit_end_s   = (baud_r == {DIV_WIDTH{1'b0}});
   assign last_stop_s = ~stop2_r | stop_cnt_r;

   // Pop from IDLE, or straight out of the final stop bit so frames run back to back.
   always_comb begin
      pop_s = 1'b0;
      if (cfg_en_i && !fifo_empty_s) begin
         if (state_r == IDLE) begin
            pop_s = 1'b1;
         end else if (state_r == STOP && bit_end_s && last_stop_s) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // Frame FSM; tx_r follows the state one cycle later so the line is glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         div_r      <= {DIV_WIDTH{1'b0}};
         baud_r     <= {DIV_WIDTH{1'b0}};
         shift_r    <= {UART_DATA_BITS{1'b0}};
         bit_r      <= 3'd0;
         stop2_r    <= 1'b0;
         stop_cnt_r <= 1'b0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r   <= 1'b0;
`endif
      end else begin
         busy_r <= (state_r != IDLE) || !fifo_empty_s;

         case (state_r)
            IDLE:    tx_r <= 1'b1;
            START:   tx_r <= 1'b0;
            DATA:    tx_r <= shift_r[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_r <= parity_r;
`else
            PARITY:  tx_r <= 1'b1;
`endif
            STOP:    tx_r <= 1'b1;
            default: tx_r <= 1'b1;
         endcase

         if (pop_s) begin
            shift_r    <= fifo_rdata_s;
            div_r      <= cfg_div_i;
            baud_r     <= cfg_div_i;
            stop2_r    <= cfg_stop2_i;
            stop_cnt_r <= 1'b0;
            bit_r      <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= frame_parity(fifo_rdata_s, cfg_parity_odd_i);
`endif
            state_r    <= START;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               START: begin
                  if (bit_end_s) begin
                     baud_r  <= div_r;
                     state_r <= DATA;
                  end else begin
                     baud_r  <= baud_r - DIV_WIDTH'(1);
                  end
               end
               DATA: begin
                  if (bit_end_s) begin
                     baud_r  <= div_r;
                     shift_r <= {1'b0, shift_r[UART_DATA_BITS-1:1]};
                     bit_r   <= bit_r + 3'd1;
                     if (bit_r == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_r <= PARITY;
`else
                        state_r <= STOP;
`endif
                     end
                  end else begin
                     baud_r  <= baud_r - DIV_WIDTH'(1);
                  end
               end
               PARITY: begin
                  if (bit_end_s) begin
                     baud_r  <= div_r;
                     state_r <= STOP;
                  end else begin
                     baud_r  <= baud_r - DIV_WIDTH'(1);
                  end
               end
               STOP: begin
                  if (bit_end_s) begin
                     if (last_stop_s) begin
                        state_r <= IDLE;
                     end else begin
                        stop_cnt_r <= 1'b1;
                        baud_r     <= div_r;
                     end
                  end else begin
                     baud_r <= baud_r - DIV_WIDTH'(1);
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign tx_if.tx_ready_o = ~fifo_full_s;
   assign busy_o           = busy_r;
   assign tx_o             = tx_r;

endmodule
